// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller.
// A serially loaded {START,STOP,STEP} configuration is copied into a shadow
// register on LOAD, and into the active register on GO. The controller then
// steps the increment word from START towards STOP once per step period,
// holds STOP for one more period, pulses DONE, and either stops or repeats.
//
// Handshake: LOAD, GO and ABORT are single-cycle strobes sampled on the
// rising edge of CLK; they have no ready/acknowledge. GO is accepted only in
// IDLE with a valid shadow config. ABORT has priority over everything else.
// DONE is a registered one-cycle pulse.
module freq_sweep_ctrl #(
  parameter int INCR_W   = 9,
  parameter int TICK_MAX = 25_000_000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SER_EN,
  input  logic              SER_IN,
  input  logic              LOAD,
  input  logic              GO,
  input  logic              ABORT,
  input  logic              MODE,
  output logic [INCR_W-1:0] INCR,
  output logic              BUSY,
  output logic              DONE,
  output logic              CFG_ERR,
  output logic [1:0]        STATE
);

  localparam int CFG_W  = 3 * INCR_W;
  localparam int TICK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(TICK_MAX);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_FINISH = 2'b10;

  logic [CFG_W-1:0]  sr_q, sr_d;
  logic [CFG_W-1:0]  shadow_q, shadow_d;
  logic [CFG_W-1:0]  active_q, active_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [INCR_W-1:0] incr_q, incr_d;
  logic [1:0]        state_q, state_d;
  logic              done_q, done_d;

  // Field views of the shadow and active configs.
  logic [INCR_W-1:0] sh_start, sh_stop, sh_step;
  logic [INCR_W-1:0] act_start, act_stop, act_step;
  logic [INCR_W:0]   sum;
  logic              sum_ge;
  logic              tick;
  logic              cfg_err;

  assign sh_start  = shadow_q[CFG_W-1 -: INCR_W];
  assign sh_stop   = shadow_q[2*INCR_W-1 -: INCR_W];
  assign sh_step   = shadow_q[INCR_W-1:0];
  assign act_start = active_q[CFG_W-1 -: INCR_W];
  assign act_stop  = active_q[2*INCR_W-1 -: INCR_W];
  assign act_step  = active_q[INCR_W-1:0];

  // One extra bit on the sum so a step past the top of the range cannot wrap.
  assign sum     = {1'b0, incr_q} + {1'b0, act_step};
  assign sum_ge  = (sum >= {1'b0, act_stop});
  assign tick    = (tick_q == TICK_END);
  assign cfg_err = (sh_step == '0) || (sh_start > sh_stop);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr_q     <= '0;
      shadow_q <= '0;
      active_q <= '0;
      tick_q   <= '0;
      incr_q   <= '0;
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      tick_q   <= tick_d;
      incr_q   <= incr_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; ABORT overrides GO and ticks.
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (GO && !cfg_err) state_d = ST_RUN;
        ST_RUN:    if (tick && sum_ge) state_d = ST_FINISH;
        ST_FINISH: if (tick) state_d = MODE ? ST_RUN : ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: config shifting/loading, tick counter, increment word.
  always_comb begin
    // LOAD sees the pre-shift contents because it samples sr_q, not sr_d.
    sr_d     = SER_EN ? {sr_q[CFG_W-2:0], SER_IN} : sr_q;
    shadow_d = LOAD ? sr_q : shadow_q;
    active_d = active_q;
    tick_d   = tick_q;
    incr_d   = incr_q;
    done_d   = 1'b0;
    if (ABORT) begin
      tick_d = '0;
      incr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          if (GO && !cfg_err) begin
            active_d = shadow_q;
            incr_d   = sh_start;
          end
        end
        ST_RUN: begin
          tick_d = tick ? '0 : tick_q + TICK_W'(1);
          if (tick) incr_d = sum_ge ? act_stop : sum[INCR_W-1:0];
        end
        ST_FINISH: begin
          tick_d = tick ? '0 : tick_q + TICK_W'(1);
          if (tick) begin
            done_d = 1'b1;
            incr_d = MODE ? act_start : '0;
          end
        end
        default: begin
          tick_d = '0;
          incr_d = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    BUSY    = (state_q == ST_RUN) || (state_q == ST_FINISH);
    STATE   = state_q;
    INCR    = incr_q;
    DONE    = done_q;
    CFG_ERR = cfg_err;
  end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl with INCR_W=9, TICK_MAX=3 (4-cycle step period).
// Cycle k below is the observation point 1 ns after the k-th rising edge that
// follows the GO edge (k=0 is just after GO is taken).
module tb_freq_sweep_ctrl;
  localparam int W  = 9;
  localparam int TM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_en = 1'b0, ser_in = 1'b0, load = 1'b0, go = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [W-1:0] incr;
  logic         busy, done, cfg_err;
  logic [1:0]   state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Clock and DUT.
  always #5 clk = ~clk;

  freq_sweep_ctrl #(.INCR_W(W), .TICK_MAX(TM)) dut (
    .CLK(clk), .RST_N(rst_n), .SER_EN(ser_en), .SER_IN(ser_in),
    .LOAD(load), .GO(go), .ABORT(abort), .MODE(mode),
    .INCR(incr), .BUSY(busy), .DONE(done), .CFG_ERR(cfg_err), .STATE(state)
  );

  // Comparison helper.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic shift_cfg(input logic [W-1:0] s_start, input logic [W-1:0] s_stop,
                           input logic [W-1:0] s_step);
    logic [3*W-1:0] bits;
    bits = {s_start, s_stop, s_step};
    for (int i = 3*W-1; i >= 0; i--) begin
      ser_en = 1'b1;
      ser_in = bits[i];
      step_clk();
    end
    ser_en = 1'b0;
    ser_in = 1'b0;
  endtask

  task automatic load_pulse();
    load = 1'b1;
    step_clk();
    load = 1'b0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    step_clk();
    go = 1'b0;
  endtask

  task automatic abort_pulse();
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #2;
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_incr", incr, 0);
    check("rst_cfg_err", cfg_err, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_clk();

    // GO before any LOAD is ignored.
    go_pulse();
    check("go_noload_state", state, 0);
    check("go_noload_incr", incr, 0);

    // STEP==0 config is rejected.
    shift_cfg(9'd10, 9'd40, 9'd0);
    load_pulse();
    check("step0_cfg_err", cfg_err, 1);
    go_pulse();
    check("step0_state", state, 0);
    check("step0_incr", incr, 0);

    // START>STOP config is rejected.
    shift_cfg(9'd40, 9'd10, 9'd5);
    load_pulse();
    check("rev_cfg_err", cfg_err, 1);
    go_pulse();
    check("rev_state", state, 0);

    // Single sweep 10..40 step 10.
    shift_cfg(9'd10, 9'd40, 9'd10);
    load_pulse();
    check("s1_cfg_err", cfg_err, 0);
    for (int k = 0; k < 16; k++) exp_q.push_back(W'(10 + 10 * (k / 4)));
    exp_q.push_back(9'd0);
    mode = 1'b0;
    go_pulse();
    for (int k = 0; k <= 16; k++) begin
      check($sformatf("s1_incr_k%0d", k), incr, exp_q.pop_front());
      check($sformatf("s1_done_k%0d", k), done, (k == 16) ? 1 : 0);
      if (k == 0)  check("s1_state_run", state, 1);
      if (k == 11) check("s1_state_run_last", state, 1);
      if (k == 12) check("s1_state_finish", state, 2);
      if (k == 15) check("s1_busy_finish", busy, 1);
      if (k == 16) begin
        check("s1_state_idle", state, 0);
        check("s1_busy_idle", busy, 0);
      end
      if (k < 16) step_clk();
    end
    step_clk();
    check("s1_done_drop", done, 0);

    // Repeat mode: returns to START after DONE and stays busy.
    mode = 1'b1;
    go_pulse();
    steps(16);
    check("rep_done", done, 1);
    check("rep_incr_restart", incr, 10);
    check("rep_state", state, 1);
    check("rep_busy", busy, 1);
    step_clk();
    check("rep_done_drop", done, 0);
    steps(3);
    check("rep_incr_2nd", incr, 20);
    abort_pulse();
    check("rep_abort_state", state, 0);
    check("rep_abort_incr", incr, 0);
    check("rep_abort_busy", busy, 0);
    mode = 1'b0;

    // ABORT coinciding with a RUN tick.
    go_pulse();
    steps(3);
    abort_pulse();
    check("ab_state", state, 0);
    check("ab_incr", incr, 0);
    check("ab_done", done, 0);
    step_clk();
    check("ab_done_later", done, 0);
    check("ab_state_later", state, 0);
    // Restart at START; a GO during RUN must not restart the tick counter.
    go_pulse();
    check("ab_restart_incr", incr, 10);
    go = 1'b1;
    step_clk();
    go = 1'b0;
    steps(2);
    check("go_in_run_k3", incr, 10);
    step_clk();
    check("go_in_run_k4", incr, 20);
    abort_pulse();

    // Top of range: 500 + 20 must clamp to 511, not wrap.
    shift_cfg(9'd500, 9'd511, 9'd20);
    load_pulse();
    check("top_cfg_err", cfg_err, 0);
    go_pulse();
    check("top_incr_start", incr, 500);
    steps(4);
    check("top_incr_stop", incr, 511);
    check("top_state_finish", state, 2);
    steps(4);
    check("top_done", done, 1);
    check("top_incr_end", incr, 0);
    check("top_state_idle", state, 0);

    // START==STOP: two periods at STOP.
    shift_cfg(9'd50, 9'd50, 9'd1);
    load_pulse();
    go_pulse();
    check("eq_incr_k0", incr, 50);
    check("eq_state_k0", state, 1);
    steps(4);
    check("eq_incr_k4", incr, 50);
    check("eq_state_k4", state, 2);
    steps(3);
    check("eq_done_k7", done, 0);
    check("eq_incr_k7", incr, 50);
    step_clk();
    check("eq_done_k8", done, 1);
    check("eq_incr_k8", incr, 0);
    check("eq_state_k8", state, 0);

    // LOAD during RUN affects only the next GO.
    shift_cfg(9'd10, 9'd40, 9'd10);
    load_pulse();
    shift_cfg(9'd20, 9'd30, 9'd5);
    go_pulse();
    steps(2);
    load = 1'b1;
    step_clk();
    load = 1'b0;
    check("ld_run_cfg_err", cfg_err, 0);
    check("ld_run_incr_k3", incr, 10);
    step_clk();
    check("ld_run_incr_k4", incr, 20);
    steps(8);
    check("ld_run_incr_k12", incr, 40);
    check("ld_run_state_k12", state, 2);
    steps(4);
    check("ld_run_done", done, 1);
    check("ld_run_idle", state, 0);
    go_pulse();
    check("ld_new_start", incr, 20);
    steps(4);
    check("ld_new_step", incr, 25);
    steps(4);
    check("ld_new_stop", incr, 30);
    check("ld_new_finish", state, 2);

    // Asynchronous reset mid-sweep, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_incr", incr, 0);
    check("arst_busy", busy, 0);
    check("arst_cfg_err", cfg_err, 1);
    step_clk();
    rst_n = 1'b1;
    step_clk();
    go_pulse();
    check("arst_go_ignored", state, 0);
    // Shift register was cleared too: LOAD without shifting gives an invalid config.
    load_pulse();
    check("arst_sr_cleared", cfg_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter INCR_W, default 9, width of the increment word driven to the phase-accumulator counter.
REQ-002 SHALL have parameter TICK_MAX, default 25_000_000, terminal value of the internal step-period counter (period = TICK_MAX+1 cycles).
REQ-003 SHALL have port CLK  input  1  clock, rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port SER_EN  input  1  serial config shift enable.
REQ-006 SHALL have port SER_IN  input  1  serial config bit, MSB first.
REQ-007 SHALL have port LOAD  input  1  one-cycle pulse; copy the config shift register into the shadow config.
REQ-008 SHALL have port GO  input  1  one-cycle pulse; start a sweep.
REQ-009 SHALL have port ABORT  input  1  one-cycle pulse; stop the sweep immediately.
REQ-010 SHALL have port MODE  input  1  0 = single sweep, 1 = repeat; sampled at each end of sweep.
REQ-011 SHALL have port INCR  output  INCR_W  increment word to the phase accumulator.
REQ-012 SHALL have port BUSY  output  1  high in RUN or FINISH.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse at end of each sweep.
REQ-014 SHALL have port CFG_ERR  output  1  shadow config invalid.
REQ-015 SHALL have port STATE  output  2  current FSM state code.

Function
REQ-016 Config shift register SHALL be 3*INCR_W bits, laid out {START,STOP,STEP}; when SER_EN=1 it shifts left by one and SER_IN enters the LSB; otherwise it holds.
REQ-017 LOAD SHALL capture the shift-register value present before any same-cycle shift into the shadow config.
REQ-018 CFG_ERR SHALL be combinational from the shadow config: 1 when STEP==0 or START>STOP.
REQ-019 FSM states SHALL be IDLE=2'b00, RUN=2'b01, FINISH=2'b10; code 2'b11 SHALL go to IDLE on the next edge.
REQ-020 In IDLE, GO with CFG_ERR=0 SHALL copy the shadow config into the active config, set INCR=START, clear the tick counter, and enter RUN on the same edge.
REQ-021 In IDLE, GO with CFG_ERR=1 SHALL be ignored.
REQ-022 Tick counter SHALL run 0..TICK_MAX and wrap in RUN and FINISH; a tick is the cycle with count==TICK_MAX.
REQ-023 On a tick in RUN, the block SHALL compute INCR+STEP in INCR_W+1 bits.
REQ-024 If that sum is >= STOP, the block SHALL set INCR=STOP and enter FINISH; otherwise it SHALL set INCR to the sum.
REQ-025 On a tick in FINISH, DONE SHALL pulse for exactly one cycle.
REQ-026 On that FINISH tick with MODE=1, the block SHALL set INCR=START from the active config and enter RUN.
REQ-027 On that FINISH tick with MODE=0, the block SHALL set INCR=0 and enter IDLE.
REQ-028 START==STOP SHALL go RUN->FINISH on the first tick, giving 2 tick periods at STOP in total.
REQ-029 GO outside IDLE SHALL be ignored.
REQ-030 LOAD outside IDLE SHALL update the shadow config only; the active config changes only at the next GO.
REQ-031 ABORT in any state SHALL force IDLE, INCR=0, and a cleared tick counter, with no DONE pulse.
REQ-032 ABORT SHALL win over a simultaneous GO or tick.
REQ-033 INCR SHALL be registered; the accumulator sees a new value one cycle after the deciding edge.

Reset
REQ-034 RST_N=0 SHALL asynchronously clear the shift register, shadow config, active config, tick counter and INCR; STATE=IDLE, BUSY=0, DONE=0.
REQ-035 After reset CFG_ERR SHALL be 1, because STEP==0.
REQ-036 Reset asserted mid-sweep SHALL take effect without waiting for a clock edge.
REQ-037 The first GO after reset SHALL require a valid LOAD.

Verification (bench uses INCR_W=9, TICK_MAX=3)
REQ-038 Shift in START=10, STOP=40, STEP=10, LOAD, GO with MODE=0 -> INCR=10,20,30,40 at 4-cycle spacing; 40 held one extra period; DONE pulses once; INCR=0; IDLE.
REQ-039 Same config, MODE=1 -> after DONE, INCR returns to 10 and the sequence repeats; BUSY stays 1.
REQ-040 START=500, STOP=511, STEP=20 -> INCR goes 500 then 511, with no 9-bit wrap to 8.
REQ-041 LOAD with STEP=0 then GO -> CFG_ERR=1, STATE stays IDLE, INCR=0.
REQ-042 ABORT asserted in the same cycle as a RUN tick -> IDLE, INCR=0, no DONE; a following GO restarts at START.
REQ-043 LOAD of a new config during RUN -> the current sweep finishes with the old values; the next GO uses the new values.
